// File: rtl/replay_fifo_pkg.sv
// Shared parameters, pointer-width helper and request vector for the replay FIFO.
package replay_fifo_pkg;

    localparam int unsigned WIDTH_DEF = 2;
    localparam int unsigned DEPTH_DEF = 256;

    // Pointer carries one extra wrap bit above the storage address.
    function automatic int ptr_w(int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic enqueue;
        logic dequeue;
        logic commit;
        logic recover;
    } req_t;

endpackage

// File: rtl/replay_fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port, no reset.
module replay_fifo_mem #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/replay_fifo.sv
// Circular FIFO with commit/recover replay. Optional sticky overflow/underflow
// outputs are built when REPLAY_FIFO_ERR_EN is defined.
module replay_fifo
    import replay_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enqueue,
    input  logic [WIDTH-1:0]       din,
    input  logic                   dequeue,
    input  logic                   commit,
    input  logic                   recover,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
`ifdef REPLAY_FIFO_ERR_EN
    output logic                   overflow,
    output logic                   underflow,
`endif
    output logic [$clog2(DEPTH):0] count,
    output logic [$clog2(DEPTH):0] held
);

    localparam int PW = ptr_w(int'(DEPTH));
    localparam int AW = PW - 1;

    req_t          req;
    logic [PW-1:0] wr_q, rd_q, cm_q;
    logic [PW-1:0] wr_d, rd_d, cm_d;
    logic [PW-1:0] occupied;
    logic          enq_ok, deq_ok;
    logic [WIDTH-1:0] rdata;

    assign req = {enqueue, dequeue, commit, recover};

    assign occupied = wr_q - cm_q;
    assign full     = (occupied == PW'(DEPTH));
    assign empty    = (wr_q == rd_q);
    assign count    = wr_q - rd_q;
    assign held     = rd_q - cm_q;
    assign dout     = empty ? '0 : rdata;

    // Dequeue never frees space, so an enqueue on full is refused even with a dequeue.
    assign enq_ok = req.enqueue && !full;
    assign deq_ok = req.dequeue && !empty && !req.recover;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        cm_d = cm_q;
        if (enq_ok) begin
            wr_d = wr_q + PW'(1);
        end
        if (req.recover) begin
            rd_d = cm_q;
        end else if (deq_ok) begin
            rd_d = rd_q + PW'(1);
        end
        // Commit takes the post-dequeue read pointer so a same-cycle dequeue is included.
        if (req.commit && !req.recover) begin
            cm_d = rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            cm_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            cm_q <= cm_d;
        end
    end

    replay_fifo_mem #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (enq_ok),
        .waddr(wr_q[AW-1:0]),
        .wdata(din),
        .raddr(rd_q[AW-1:0]),
        .rdata(rdata)
    );

`ifdef REPLAY_FIFO_ERR_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (req.enqueue && full) begin
                overflow_q <= 1'b1;
            end
            if (req.dequeue && empty && !req.recover) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_replay_fifo.sv
// Scoreboard bench for replay_fifo (WIDTH=4, DEPTH=4): delivered data is queued at
// enqueue, moved to a held list at dequeue, and returned to the queue on recover.
module tb_replay_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enqueue = 1'b0;
    logic [3:0] din = '0;
    logic       dequeue = 1'b0;
    logic       commit = 1'b0;
    logic       recover = 1'b0;
    logic [3:0] dout;
    logic       full, empty;
    logic [2:0] count, held;
`ifdef REPLAY_FIFO_ERR_EN
    logic       overflow, underflow;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    logic [3:0] exp_q[$];
    logic [3:0] held_q[$];
    logic [3:0] exp_d;

    always #5 clk = ~clk;

    replay_fifo #(
        .WIDTH(4),
        .DEPTH(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enqueue  (enqueue),
        .din      (din),
        .dequeue  (dequeue),
        .commit   (commit),
        .recover  (recover),
        .dout     (dout),
        .full     (full),
        .empty    (empty),
`ifdef REPLAY_FIFO_ERR_EN
        .overflow (overflow),
        .underflow(underflow),
`endif
        .count    (count),
        .held     (held)
    );

    // Apply the driven inputs for one edge, then release them 1 time unit after it.
    task automatic cyc();
        @(posedge clk);
        #1;
        rst = 1'b0;
        enqueue = 1'b0;
        dequeue = 1'b0;
        commit = 1'b0;
        recover = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        exp_q.delete();
        held_q.delete();
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %0b want 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b want 0", full); end
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (held !== 3'd0) begin n_fail++; $display("FAIL reset_held: got %0d want 0", held); end
        n_cmp++; if (dout !== 4'd0) begin n_fail++; $display("FAIL reset_dout: got %0d want 0", dout); end
`ifdef REPLAY_FIFO_ERR_EN
        n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_err: got %0b%0b want 00", overflow, underflow);
        end
`endif
    endtask

    task automatic test_enqueue();
        for (int i = 5; i <= 7; i++) begin
            enqueue = 1'b1;
            din = 4'(i);
            exp_q.push_back(4'(i));
            cyc();
        end
        n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL enq_count: got %0d want 3", count); end
        n_cmp++; if (empty !== 1'b0) begin n_fail++; $display("FAIL enq_empty: got %0b want 0", empty); end
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL enq_full: got %0b want 0", full); end
        n_cmp++; if (dout !== exp_q[0]) begin n_fail++; $display("FAIL enq_dout: got %0d want %0d", dout, exp_q[0]); end
    endtask

    task automatic test_recover();
        for (int i = 0; i < 2; i++) begin
            exp_d = exp_q.pop_front();
            held_q.push_back(exp_d);
            n_cmp++; if (dout !== exp_d) begin n_fail++; $display("FAIL rec_pre_dout%0d: got %0d want %0d", i, dout, exp_d); end
            dequeue = 1'b1;
            cyc();
        end
        n_cmp++; if (held !== 3'd2) begin n_fail++; $display("FAIL rec_held_before: got %0d want 2", held); end
        n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL rec_count_before: got %0d want 1", count); end
        recover = 1'b1;
        exp_q = {held_q, exp_q};
        held_q.delete();
        cyc();
        n_cmp++; if (held !== 3'd0) begin n_fail++; $display("FAIL rec_held_after: got %0d want 0", held); end
        n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL rec_count_after: got %0d want 3", count); end
        for (int i = 0; i < 3; i++) begin
            exp_d = exp_q.pop_front();
            held_q.push_back(exp_d);
            n_cmp++; if (dout !== exp_d) begin n_fail++; $display("FAIL rec_replay%0d: got %0d want %0d", i, dout, exp_d); end
            dequeue = 1'b1;
            cyc();
        end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rec_drained: got %0b want 1", empty); end
    endtask

    task automatic test_commit();
        recover = 1'b1;
        exp_q = {held_q, exp_q};
        held_q.delete();
        cyc();
        for (int i = 0; i < 3; i++) begin
            exp_d = exp_q.pop_front();
            held_q.push_back(exp_d);
            n_cmp++; if (dout !== exp_d) begin n_fail++; $display("FAIL cm_dout%0d: got %0d want %0d", i, dout, exp_d); end
            dequeue = 1'b1;
            if (i == 1) begin
                commit = 1'b1;
                held_q.delete();
            end
            cyc();
        end
        n_cmp++; if (held !== 3'd1) begin n_fail++; $display("FAIL cm_held_pre: got %0d want 1", held); end
        recover = 1'b1;
        exp_q = {held_q, exp_q};
        held_q.delete();
        cyc();
        n_cmp++; if (held !== 3'd0) begin n_fail++; $display("FAIL cm_held: got %0d want 0", held); end
        n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL cm_count: got %0d want 1", count); end
        n_cmp++; if (dout !== exp_q[0]) begin n_fail++; $display("FAIL cm_dout: got %0d want %0d", dout, exp_q[0]); end
    endtask

    task automatic test_full();
        rst = 1'b1;
        cyc();
        exp_q.delete();
        held_q.delete();
        for (int i = 1; i <= 4; i++) begin
            enqueue = 1'b1;
            din = 4'(i);
            exp_q.push_back(4'(i));
            cyc();
        end
        n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_set: got %0b want 1", full); end
        // Enqueue alongside a dequeue on full must still be refused.
        for (int i = 0; i < 4; i++) begin
            exp_d = exp_q.pop_front();
            held_q.push_back(exp_d);
            n_cmp++; if (dout !== exp_d) begin n_fail++; $display("FAIL full_dout%0d: got %0d want %0d", i, dout, exp_d); end
            dequeue = 1'b1;
            enqueue = (i == 0);
            din = 4'd9;
            cyc();
        end
        n_cmp++; if (empty !== 1'b1 || full !== 1'b1) begin
            n_fail++; $display("FAIL full_drained: got empty=%0b full=%0b want 1 1", empty, full);
        end
        n_cmp++; if (held !== 3'd4) begin n_fail++; $display("FAIL full_held: got %0d want 4", held); end
        enqueue = 1'b1;
        din = 4'd9;
        cyc();
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL full_drop: got count=%0d want 0", count); end
        dequeue = 1'b1;
        cyc();
`ifdef REPLAY_FIFO_ERR_EN
        n_cmp++; if (overflow !== 1'b1 || underflow !== 1'b1) begin
            n_fail++; $display("FAIL full_err: got %0b%0b want 11", overflow, underflow);
        end
`endif
        commit = 1'b1;
        held_q.delete();
        cyc();
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL full_commit: got %0b want 0", full); end
        n_cmp++; if (held !== 3'd0) begin n_fail++; $display("FAIL full_commit_held: got %0d want 0", held); end
        enqueue = 1'b1;
        din = 4'd9;
        exp_q.push_back(4'd9);
        cyc();
        n_cmp++; if (count !== 3'd1 || dout !== exp_q[0]) begin
            n_fail++; $display("FAIL full_accept: got count=%0d dout=%0d want 1 %0d", count, dout, exp_q[0]);
        end
    endtask

    task automatic test_back_to_back();
        rst = 1'b1;
        cyc();
        exp_q.delete();
        held_q.delete();
        enqueue = 1'b1;
        din = 4'd1;
        exp_q.push_back(4'd1);
        cyc();
        for (int i = 1; i <= 20; i++) begin
            exp_d = exp_q.pop_front();
            n_cmp++; if (dout !== exp_d) begin n_fail++; $display("FAIL b2b_dout%0d: got %0d want %0d", i, dout, exp_d); end
            enqueue = 1'b1;
            dequeue = 1'b1;
            commit = 1'b1;
            din = 4'(i + 1);
            exp_q.push_back(4'(i + 1));
            cyc();
            n_cmp++; if (count !== 3'd1 || held !== 3'd0) begin
                n_fail++; $display("FAIL b2b_ptr%0d: got count=%0d held=%0d want 1 0", i, count, held);
            end
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        cyc();
        exp_q.delete();
        held_q.delete();
        for (int i = 1; i <= 3; i++) begin
            enqueue = 1'b1;
            din = 4'(i + 10);
            cyc();
        end
        enqueue = 1'b1;
        dequeue = 1'b1;
        din = 4'd14;
        cyc();
        n_cmp++; if (count !== 3'd3 || held !== 3'd1) begin
            n_fail++; $display("FAIL mid_pre: got count=%0d held=%0d want 3 1", count, held);
        end
        rst = 1'b1;
        cyc();
        n_cmp++; if (empty !== 1'b1 || full !== 1'b0 || count !== 3'd0 || held !== 3'd0 || dout !== 4'd0) begin
            n_fail++; $display("FAIL mid_rst: got e=%0b f=%0b c=%0d h=%0d d=%0d want 1 0 0 0 0",
                               empty, full, count, held, dout);
        end
        recover = 1'b1;
        cyc();
        n_cmp++; if (empty !== 1'b1 || count !== 3'd0 || held !== 3'd0 || dout !== 4'd0) begin
            n_fail++; $display("FAIL mid_recover: got e=%0b c=%0d h=%0d d=%0d want 1 0 0 0",
                               empty, count, held, dout);
        end
    endtask

    initial begin
        test_reset();
        test_enqueue();
        test_recover();
        test_commit();
        test_full();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
